// File: rtl/multiplier_dsp_pipe.sv
// Fully pipelined WIDTH x WIDTH multiplier with low/high-half, signed-high and
// multiply-accumulate modes; a tag rides alongside each operation.
module multiplier_dsp_pipe #(
  parameter int WIDTH     = 16,
  parameter int LATENCY   = 2,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [1:0]           mode,
  input  logic                 acc_clear,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 valid_out,
  output logic [WIDTH-1:0]     out,
  output logic [TAG_WIDTH-1:0] tag_out
);

  localparam logic [1:0] MODE_MUL_LO = 2'd0;
  localparam logic [1:0] MODE_MULHU  = 2'd1;
  localparam logic [1:0] MODE_MULHS  = 2'd2;
  localparam logic [1:0] MODE_MAC    = 2'd3;
  localparam int PW = 2 * WIDTH;
  localparam int NS = LATENCY - 1;

  logic                 r_s0_valid;
  logic [1:0]           r_s0_mode;
  logic                 r_s0_clr;
  logic [WIDTH-1:0]     r_s0_a;
  logic [WIDTH-1:0]     r_s0_b;
  logic [TAG_WIDTH-1:0] r_s0_tag;

  // Operand capture; only the valid bit needs clearing on reset.
  always_ff @(posedge clk) begin
    r_s0_mode <= mode;
    r_s0_clr  <= acc_clear;
    r_s0_a    <= in0;
    r_s0_b    <= in1;
    r_s0_tag  <= tag_in;
    if (rst) begin
      r_s0_valid <= 1'b0;
    end else begin
      r_s0_valid <= valid_in;
    end
  end

  // Sign-extending only for MULHS lets one 2W-bit multiply serve every mode.
  logic          w_signed;
  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_b_ext;
  logic [PW-1:0] w_prod;

  assign w_signed = (r_s0_mode == MODE_MULHS);
  assign w_a_ext  = {{WIDTH{w_signed & r_s0_a[WIDTH-1]}}, r_s0_a};
  assign w_b_ext  = {{WIDTH{w_signed & r_s0_b[WIDTH-1]}}, r_s0_b};
  assign w_prod   = w_a_ext * w_b_ext;

  logic [PW-1:0]        r_p   [1:NS];
  logic                 r_v   [1:NS];
  logic [1:0]           r_m   [1:NS];
  logic                 r_c   [1:NS];
  logic [TAG_WIDTH-1:0] r_t   [1:NS];

  always_ff @(posedge clk) begin
    r_p[1] <= w_prod;
    r_m[1] <= r_s0_mode;
    r_c[1] <= r_s0_clr;
    r_t[1] <= r_s0_tag;
    if (rst) begin
      r_v[1] <= 1'b0;
    end else begin
      r_v[1] <= r_s0_valid;
    end
  end

  genvar gi;
  generate
    for (gi = 2; gi <= NS; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        r_p[gi] <= r_p[gi-1];
        r_m[gi] <= r_m[gi-1];
        r_c[gi] <= r_c[gi-1];
        r_t[gi] <= r_t[gi-1];
        if (rst) begin
          r_v[gi] <= 1'b0;
        end else begin
          r_v[gi] <= r_v[gi-1];
        end
      end
    end
  endgenerate

  // The accumulator is read and written only here, so back-to-back MACs chain.
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_mac;
  logic [WIDTH-1:0] w_result;

  assign w_lo   = r_p[NS][WIDTH-1:0];
  assign w_hi   = r_p[NS][PW-1:WIDTH];
  assign w_base = r_c[NS] ? '0 : r_acc;
  assign w_mac  = w_base + w_lo;

  always_comb begin
    w_result = w_lo;
    case (r_m[NS])
      MODE_MUL_LO: w_result = w_lo;
      MODE_MULHU:  w_result = w_hi;
      MODE_MULHS:  w_result = w_hi;
      MODE_MAC:    w_result = w_mac;
      default:     w_result = w_lo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      out       <= '0;
      tag_out   <= '0;
      r_acc     <= '0;
    end else begin
      valid_out <= r_v[NS];
      if (r_v[NS]) begin
        out     <= w_result;
        tag_out <= r_t[NS];
        if (r_m[NS] == MODE_MAC) begin
          r_acc <= w_mac;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiplier_dsp_pipe.sv
// Bench for multiplier_dsp_pipe: three instances (16/2, 16/4, 32/5) driven by
// directed scenarios and random streams against an arithmetic reference model.
module tb_multiplier_dsp_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rst_s [3];
  logic        vin   [3];
  logic [1:0]  md    [3];
  logic        cl    [3];
  logic [31:0] a_s   [3];
  logic [31:0] b_s   [3];
  logic [3:0]  tg    [3];
  logic [31:0] macc  [3];

  logic        vo_a, vo_b, vo_c;
  logic [15:0] out_a, out_b;
  logic [31:0] out_c;
  logic [3:0]  tag_a, tag_b, tag_c;

  multiplier_dsp_pipe #(.WIDTH(16), .LATENCY(2), .TAG_WIDTH(4)) u_a (
    .clk(clk), .rst(rst_s[0]), .valid_in(vin[0]), .mode(md[0]), .acc_clear(cl[0]),
    .in0(a_s[0][15:0]), .in1(b_s[0][15:0]), .tag_in(tg[0]),
    .valid_out(vo_a), .out(out_a), .tag_out(tag_a));

  multiplier_dsp_pipe #(.WIDTH(16), .LATENCY(4), .TAG_WIDTH(4)) u_b (
    .clk(clk), .rst(rst_s[1]), .valid_in(vin[1]), .mode(md[1]), .acc_clear(cl[1]),
    .in0(a_s[1][15:0]), .in1(b_s[1][15:0]), .tag_in(tg[1]),
    .valid_out(vo_b), .out(out_b), .tag_out(tag_b));

  multiplier_dsp_pipe #(.WIDTH(32), .LATENCY(5), .TAG_WIDTH(4)) u_c (
    .clk(clk), .rst(rst_s[2]), .valid_in(vin[2]), .mode(md[2]), .acc_clear(cl[2]),
    .in0(a_s[2]), .in1(b_s[2]), .tag_in(tg[2]),
    .valid_out(vo_c), .out(out_c), .tag_out(tag_c));

  function automatic logic get_vo(int s);
    return (s == 0) ? vo_a : (s == 1) ? vo_b : vo_c;
  endfunction

  function automatic logic [31:0] get_out(int s);
    return (s == 0) ? {16'd0, out_a} : (s == 1) ? {16'd0, out_b} : out_c;
  endfunction

  function automatic logic [3:0] get_tag(int s);
    return (s == 0) ? tag_a : (s == 1) ? tag_b : tag_c;
  endfunction

  task automatic set_in(int s, logic v, logic [1:0] m, logic c,
                        logic [31:0] a, logic [31:0] b, logic [3:0] t);
    vin[s] = v; md[s] = m; cl[s] = c; a_s[s] = a; b_s[s] = b; tg[s] = t;
  endtask

  // Reference: full-precision products from plain integer arithmetic.
  function automatic logic [31:0] model(int w, logic [1:0] m, logic c,
                                        logic [31:0] acc, logic [31:0] a, logic [31:0] b);
    logic [63:0] mask;
    logic [63:0] pu;
    logic [63:0] ps;
    longint sa;
    longint sb;
    logic [63:0] r;
    mask = (64'd1 << w) - 64'd1;
    pu   = {32'd0, a} * {32'd0, b};
    sa   = a[w-1] ? (longint'(a) - (longint'(1) << w)) : longint'(a);
    sb   = b[w-1] ? (longint'(b) - (longint'(1) << w)) : longint'(b);
    ps   = 64'(sa * sb);
    case (m)
      2'd0:    r = pu & mask;
      2'd1:    r = (pu >> w) & mask;
      2'd2:    r = (ps >> w) & mask;
      default: r = ((c ? 64'd0 : {32'd0, acc}) + (pu & mask)) & mask;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick(int w);
    logic [31:0] mk;
    mk = 32'((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 5))
      0:       return mk;
      1:       return 32'(64'd1 << (w - 1));
      2:       return 32'd1;
      default: return $urandom & mk;
    endcase
  endfunction

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      rst_s[s] = 1'b1;
      set_in(s, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 4'd0);
      macc[s] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (get_vo(s) !== 1'b0 || get_out(s) !== 32'd0 || get_tag(s) !== 4'd0)
        $display("FAIL reset dut%0d: valid=%b out=%h tag=%h, required 0/0/0",
                 s, get_vo(s), get_out(s), get_tag(s));
      if (get_vo(s) !== 1'b0 || get_out(s) !== 32'd0 || get_tag(s) !== 4'd0) errors++;
      rst_s[s] = 1'b0;
    end
  endtask

  task automatic test_mul_modes();
    logic [1:0]  m [5];
    logic [31:0] a [5];
    logic [31:0] b [5];
    logic [31:0] e [5];
    m = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2};
    a = '{32'h1234, 32'hFFFF, 32'hFFFF, 32'h8000, 32'h7FFF};
    b = '{32'h0010, 32'hFFFF, 32'hFFFF, 32'h0002, 32'h7FFF};
    e = '{32'h2340, 32'hFFFE, 32'h0000, 32'hFFFF, 32'h3FFF};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (i >= 3) begin
        if (get_vo(0) !== 1'b1 || get_out(0) !== e[i-3] || get_tag(0) !== 4'(i))
          begin
            errors++;
            $display("FAIL mul_modes op%0d: valid=%b out=%h tag=%h, required 1/%h/%h",
                     i - 3, get_vo(0), get_out(0), get_tag(0), e[i-3], 4'(i));
          end
      end else if (get_vo(0) !== 1'b0) begin
        errors++;
        $display("FAIL mul_modes early valid at step %0d: got 1, required 0", i);
      end
      if (i < 5) set_in(0, 1'b1, m[i], 1'b1, a[i], b[i], 4'(i + 3));
      else       set_in(0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    end
  endtask

  task automatic test_mac_chain();
    logic [1:0]  m [5];
    logic        c [5];
    logic [31:0] a [5];
    logic [31:0] b [5];
    logic [31:0] e [5];
    m = '{2'd3, 2'd3, 2'd0, 2'd3, 2'd3};
    c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    a = '{32'd3, 32'd5, 32'd2, 32'hFFFF, 32'd0};
    b = '{32'd4, 32'd6, 32'd2, 32'd1, 32'd0};
    e = '{32'h000C, 32'h002A, 32'h0004, 32'h0029, 32'h0029};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        checks++;
        if (get_vo(0) !== 1'b1 || get_out(0) !== e[i-3] || get_tag(0) !== 4'(i + 6)) begin
          errors++;
          $display("FAIL mac_chain op%0d: valid=%b out=%h tag=%h, required 1/%h/%h",
                   i - 3, get_vo(0), get_out(0), get_tag(0), e[i-3], 4'(i + 6));
        end
      end
      if (i < 5) set_in(0, 1'b1, m[i], c[i], a[i], b[i], 4'(i + 9));
      else       set_in(0, 1'b0, 2'd3, 1'b1, 32'hFFFF, 32'hFFFF, 4'd0);
    end
    macc[0] = 32'h0029;
  endtask

  task automatic test_reset_midflight();
    int wait_n;
    @(negedge clk); set_in(1, 1'b1, 2'd3, 1'b1, 32'd7, 32'd7, 4'd1);
    @(negedge clk); set_in(1, 1'b1, 2'd3, 1'b0, 32'd9, 32'd9, 4'd2);
    @(negedge clk); set_in(1, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 4'd0); rst_s[1] = 1'b1;
    @(negedge clk); rst_s[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (get_vo(1) !== 1'b0 || get_out(1) !== 32'd0) begin
        errors++;
        $display("FAIL flush step%0d: valid=%b out=%h, required 0/0000",
                 i, get_vo(1), get_out(1));
      end
      @(negedge clk);
    end
    set_in(1, 1'b1, 2'd3, 1'b0, 32'd2, 32'd3, 4'hA);
    @(negedge clk);
    set_in(1, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    wait_n = 1;
    while (get_vo(1) !== 1'b1 && wait_n < 12) begin
      @(negedge clk);
      wait_n++;
    end
    checks++;
    if (wait_n != 5 || get_out(1) !== 32'h0006 || get_tag(1) !== 4'hA) begin
      errors++;
      $display("FAIL post_reset_mac: latency=%0d out=%h tag=%h, required 5/0006/a",
               wait_n, get_out(1), get_tag(1));
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    int          due;
  } exp_t;

  task automatic test_stream(int s, int w, int lat);
    exp_t        q[$];
    exp_t        ex;
    int          issued = 0;
    int          seen = 0;
    int          iter = 0;
    logic        have_last = 1'b0;
    logic [31:0] last_res = '0;
    logic [3:0]  last_tag = '0;
    logic [1:0]  m;
    logic        c;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  t;
    while ((issued < 50 || q.size() != 0) && iter < 1000) begin
      @(negedge clk);
      if (get_vo(s) === 1'b1) begin
        seen++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stream%0d unexpected valid at step %0d: out=%h", s, iter, get_out(s));
        end else begin
          ex = q.pop_front();
          if (get_out(s) !== ex.res || get_tag(s) !== ex.tag || iter != ex.due) begin
            errors++;
            $display("FAIL stream%0d result: out=%h tag=%h step=%0d, required %h/%h/%0d",
                     s, get_out(s), get_tag(s), iter, ex.res, ex.tag, ex.due);
          end
          have_last = 1'b1; last_res = ex.res; last_tag = ex.tag;
        end
      end else begin
        if (q.size() != 0 && q[0].due <= iter) begin
          checks++; errors++;
          ex = q.pop_front();
          $display("FAIL stream%0d missing valid at step %0d, required out=%h tag=%h",
                   s, iter, ex.res, ex.tag);
        end
        if (have_last) begin
          checks++;
          if (get_out(s) !== last_res || get_tag(s) !== last_tag) begin
            errors++;
            $display("FAIL stream%0d hold: out=%h tag=%h, required %h/%h",
                     s, get_out(s), get_tag(s), last_res, last_tag);
          end
        end
      end
      m = 2'($urandom_range(0, 3));
      c = ($urandom_range(0, 3) == 0);
      a = pick(w);
      b = pick(w);
      t = 4'($urandom);
      if (issued < 50 && $urandom_range(0, 2) != 0) begin
        ex.res = model(w, m, c, macc[s], a, b);
        ex.tag = t;
        ex.due = iter + lat + 1;
        if (m == 2'd3) macc[s] = ex.res;
        q.push_back(ex);
        issued++;
        set_in(s, 1'b1, m, c, a, b, t);
      end else begin
        set_in(s, 1'b0, m, c, a, b, t);
      end
      iter++;
    end
    repeat (lat + 2) begin
      @(negedge clk);
      if (get_vo(s) === 1'b1) seen++;
    end
    checks++;
    if (seen != issued || q.size() != 0) begin
      errors++;
      $display("FAIL stream%0d count: valid_out=%0d pending=%0d, required %0d/0",
               s, seen, q.size(), issued);
    end
  endtask

  initial begin
    test_reset();
    test_mul_modes();
    test_mac_chain();
    test_reset_midflight();
    test_stream(0, 16, 2);
    test_stream(2, 32, 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplier_dsp_pipe.md
Name: multiplier_dsp_pipe

Overview:
- Parametrised, fully pipelined DSP multiplier; successor to the fixed 16-bit, 2-cycle multiplier.
- Adds configurable width and latency, four operation modes (low product, unsigned high, signed high, multiply-accumulate), and a tag sideband.
- Sits in the compute datapath and accepts one operation per cycle with no backpressure.

Parameters:
- WIDTH, 16, operand and result width in bits (legal 8..32).
- LATENCY, 2, cycles from a valid_in sample to valid_out (legal 2..6).
- TAG_WIDTH, 4, width of the opaque tag carried alongside each operation (legal 1..16).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  operation presented this cycle.
- mode  input  2  0=MUL_LO, 1=MULHU, 2=MULHS, 3=MAC.
- acc_clear  input  1  MAC only: treat the accumulator as zero for this operation.
- in0  input  WIDTH  operand A.
- in1  input  WIDTH  operand B.
- tag_in  input  TAG_WIDTH  sideband tag.
- valid_out  output  1  result valid.
- out  output  WIDTH  result.
- tag_out  output  TAG_WIDTH  tag of the operation producing out.

Behaviour:
- Reset: on any clk edge with rst=1:
  - all pipeline valid bits cleared;
  - valid_out=0, out=0, tag_out=0;
  - accumulator acc=0.
  - Operations in flight are discarded, and no valid_out is produced for them after rst deasserts.
- Timing:
  - An operation sampled at edge N (valid_in=1, rst=0) produces valid_out=1 for exactly one cycle after edge N+LATENCY.
  - Throughput is one op per cycle, and bubbles are preserved.
  - valid_in=0 inputs are ignored and must not disturb acc or out.
- Pipeline: mode, acc_clear, tag and valid travel with the operands through all LATENCY stages. The product is formed as a full 2*WIDTH-bit value P.
- MUL_LO: out = P[WIDTH-1:0] (unsigned and signed are identical).
- MULHU: P is the unsigned product; out = P[2*WIDTH-1:WIDTH].
- MULHS: P is the two's-complement product of signed operands; out = P[2*WIDTH-1:WIDTH].
- MAC:
  - base = 0 if acc_clear else acc;
  - R = (base + P[WIDTH-1:0]) mod 2^WIDTH, with wrap-around and no saturation or overflow flag;
  - out = R, and acc <= R on the same edge that valid_out rises.
- Accumulator ordering:
  - acc is read and updated only in the final stage, so back-to-back MACs chain correctly with no hazard.
  - Non-MAC operations never modify acc; they may be interleaved freely between MACs.
- Output holding:
  - When valid_out=0, out and tag_out hold their last valid values.
  - tag_out is updated together with out.
- Mode 3 with acc_clear=1 on the first MAC of a chain is the normal usage. acc_clear is ignored for modes 0..2.

Test Plan:
- MUL_LO / MULHU, WIDTH=16, LATENCY=2:
  - in0=0x1234, in1=0x0010, tag=0x3 -> two cycles later valid_out=1, out=0x2340, tag_out=0x3.
  - MULHU 0xFFFF*0xFFFF -> out=0xFFFE.
- MULHS:
  - 0xFFFF*0xFFFF (-1*-1) -> out=0x0000.
  - 0x8000*0x0002 -> out=0xFFFF.
  - 0x7FFF*0x7FFF -> out=0x3FFF.
- MAC chain, back-to-back cycles:
  - (3,4,clear=1) -> 0x000C; (5,6) -> 0x002A; MUL_LO (2,2) interleaved -> 0x0004 with acc unchanged; (0xFFFF,1) -> 0x0029 (wrap).
  - Final acc=0x0029.
- Reset mid-flight, LATENCY=4:
  - Issue two MACs, assert rst for one cycle in the next cycle -> no valid_out for either, out=0.
  - Subsequent MAC (2,3,clear=0) -> 0x0006.
- Streaming:
  - WIDTH=16/LATENCY=2 and WIDTH=32/LATENCY=5, 50 random ops with random valid_in gaps and all modes.
  - Every result matches the reference model exactly LATENCY cycles after issue.
  - valid_out count equals the issued count, and tags are returned in order.
